// File: rtl/game_pkg.sv
// Shared game-side types and constants used by the sprite update scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT  = 2'd1,
        CHECK = 2'd2
    } sched_state_t;

    localparam int ENT_PACMAN = 0;
    localparam int ENT_GHOST  = 1;
    localparam int ENT_GHOST1 = 2;
    localparam int N_ENT_DEF  = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge detector for a level input (e.g. vsync); one-cycle pulse on 0->1.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember last cycle's level so a rise is seen exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/entity_update_scheduler.sv
// Per-frame sequencer granting update slots to pacman, ghost, ghost1 in order,
// then sampling the collision flag and pulsing died.
module entity_update_scheduler
    import game_pkg::*;
#(
    parameter int N_ENT    = N_ENT_DEF,
    parameter int TICK_DIV = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_sync,
    input  logic             run,
    input  logic [N_ENT-1:0] upd_done,
    input  logic             collide,
    output logic [N_ENT-1:0] upd_req,
    output logic             busy,
    output logic             died,
    output logic [7:0]       frame_cnt,
    output logic             timeout_err,
    output logic             overrun
);

    localparam int SLOT_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    sched_state_t      state_q, state_n;
    logic [SLOT_W-1:0] slot_q, slot_n;
    logic [WAIT_W-1:0] wait_q, wait_n;
    logic [DIV_W-1:0]  div_q;
    logic              dead_q;
    logic              tick;
    logic              start;
    logic              timeout_set;
    logic              dead_set;
    logic              died_n;
    logic              busy_n;
    logic [N_ENT-1:0]  upd_req_n;

    sync_edge_detect u_tick (
        .clk   (clk),
        .reset (reset),
        .d     (frame_sync),
        .rise  (tick)
    );

    // A tick only starts a round when idle, on the divider's last count, and not dead.
    assign start = tick & run & ~busy & ~dead_q & (div_q == DIV_W'(TICK_DIV - 1));

    // Frame counter, tick divider, dead latch and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= 8'd0;
            div_q       <= '0;
            dead_q      <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (!run) begin
                frame_cnt <= 8'd0;
                div_q     <= '0;
                dead_q    <= 1'b0;
            end else begin
                if (tick) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (busy)
                        overrun <= 1'b1;
                    else if (div_q == DIV_W'(TICK_DIV - 1))
                        div_q <= '0;
                    else
                        div_q <= div_q + DIV_W'(1);
                end
                if (dead_set)
                    dead_q <= 1'b1;
            end
            if (timeout_set)
                timeout_err <= 1'b1;
        end
    end

    // Next-state logic: slot walk with done/timeout advance, abort when run drops.
    always_comb begin
        state_n     = state_q;
        slot_n      = slot_q;
        wait_n      = wait_q;
        died_n      = 1'b0;
        timeout_set = 1'b0;
        dead_set    = 1'b0;
        if (!run) begin
            state_n = IDLE;
            slot_n  = SLOT_W'(ENT_PACMAN);
            wait_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_n = SLOT;
                        slot_n  = SLOT_W'(ENT_PACMAN);
                        wait_n  = '0;
                    end
                end
                SLOT: begin
                    if (upd_done[slot_q] || (wait_q == WAIT_W'(TIMEOUT - 1))) begin
                        // Done takes priority over an expiring timer.
                        timeout_set = ~upd_done[slot_q];
                        wait_n      = '0;
                        if (slot_q == SLOT_W'(N_ENT - 1))
                            state_n = CHECK;
                        else
                            slot_n = slot_q + SLOT_W'(1);
                    end else begin
                        wait_n = wait_q + WAIT_W'(1);
                    end
                end
                CHECK: begin
                    state_n = IDLE;
                    if (collide) begin
                        died_n   = 1'b1;
                        dead_set = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        busy_n    = (state_n != IDLE);
        upd_req_n = (state_n == SLOT) ? (N_ENT'(1) << slot_n) : '0;
    end

    // State register with registered request/busy/died outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            wait_q  <= '0;
            upd_req <= '0;
            busy    <= 1'b0;
            died    <= 1'b0;
        end else begin
            state_q <= state_n;
            slot_q  <= slot_n;
            wait_q  <= wait_n;
            upd_req <= upd_req_n;
            busy    <= busy_n;
            died    <= died_n;
        end
    end

endmodule

// File: tb/tb_entity_update_scheduler.sv
// Directed bench for entity_update_scheduler: table-driven rounds plus
// hand-written timeout, abort, overrun, divider-wrap and reset sequences.
module tb_entity_update_scheduler;

    typedef struct {
        logic       fs;
        logic       run;
        logic [2:0] done;
        logic       col;
        logic [2:0] req;
        logic       busy;
        logic       died;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_sync;
    logic       run;
    logic [2:0] upd_done;
    logic       collide;

    logic [2:0] req_a, req_b;
    logic       busy_a, busy_b, died_a, died_b;
    logic [7:0] fcnt_a, fcnt_b;
    logic       terr_a, terr_b, ovr_a, ovr_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int r_a, r_b;
    logic pb_a, pb_b;

    vec_t t1[15];
    vec_t t2[6];

    always #5 clk = ~clk;

    entity_update_scheduler #(.N_ENT(3), .TICK_DIV(1), .TIMEOUT(8)) u_dut (
        .clk(clk), .reset(reset), .frame_sync(frame_sync), .run(run),
        .upd_done(upd_done), .collide(collide), .upd_req(req_a), .busy(busy_a),
        .died(died_a), .frame_cnt(fcnt_a), .timeout_err(terr_a), .overrun(ovr_a)
    );

    entity_update_scheduler #(.N_ENT(3), .TICK_DIV(2), .TIMEOUT(8)) u_div (
        .clk(clk), .reset(reset), .frame_sync(frame_sync), .run(run),
        .upd_done(upd_done), .collide(collide), .upd_req(req_b), .busy(busy_b),
        .died(died_b), .frame_cnt(fcnt_b), .timeout_err(terr_b), .overrun(ovr_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive inputs away from the active edge, then sample 1 time unit after it.
    task automatic step(input logic fs, input logic rn, input logic [2:0] dn, input logic cl);
        @(negedge clk);
        frame_sync = fs;
        run        = rn;
        upd_done   = dn;
        collide    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string nm, input int idx);
        step(v.fs, v.run, v.done, v.col);
        chk($sformatf("%s[%0d].upd_req", nm, idx), {29'd0, req_a}, {29'd0, v.req});
        chk($sformatf("%s[%0d].busy", nm, idx), {31'd0, busy_a}, {31'd0, v.busy});
        chk($sformatf("%s[%0d].died", nm, idx), {31'd0, died_a}, {31'd0, v.died});
    endtask

    task automatic step_cnt(input logic fs);
        step(fs, 1'b1, 3'b111, 1'b0);
        if (busy_a && !pb_a) r_a++;
        if (busy_b && !pb_b) r_b++;
        pb_a = busy_a;
        pb_b = busy_b;
    endtask

    initial begin
        int cnt;

        // Basic round: each done 3 cycles after its request, stray done[2] in slot 0.
        t1[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
        t1[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
        t1[2]  = '{1'b0, 1'b1, 3'b100, 1'b0, 3'b001, 1'b1, 1'b0};
        t1[3]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
        t1[4]  = '{1'b0, 1'b1, 3'b001, 1'b0, 3'b010, 1'b1, 1'b0};
        t1[5]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0};
        t1[6]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0};
        t1[7]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0};
        t1[8]  = '{1'b0, 1'b1, 3'b010, 1'b0, 3'b100, 1'b1, 1'b0};
        t1[9]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0};
        t1[10] = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0};
        t1[11] = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0};
        t1[12] = '{1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 1'b1, 1'b0};
        t1[13] = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
        t1[14] = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

        // Collision round: done held high, collide seen in CHECK.
        t2[0] = '{1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 1'b0};
        t2[1] = '{1'b0, 1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 1'b0};
        t2[2] = '{1'b0, 1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 1'b0};
        t2[3] = '{1'b0, 1'b1, 3'b111, 1'b1, 3'b000, 1'b1, 1'b0};
        t2[4] = '{1'b0, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1};
        t2[5] = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

        reset      = 1'b1;
        frame_sync = 1'b0;
        run        = 1'b0;
        upd_done   = 3'b000;
        collide    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.upd_req", {29'd0, req_a}, 32'd0);
        chk("rst.busy", {31'd0, busy_a}, 32'd0);
        chk("rst.died", {31'd0, died_a}, 32'd0);
        chk("rst.frame_cnt", {24'd0, fcnt_a}, 32'd0);
        chk("rst.timeout_err", {31'd0, terr_a}, 32'd0);
        chk("rst.overrun", {31'd0, ovr_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 3'b000, 1'b0);

        for (int i = 0; i < 15; i++) apply(t1[i], "basic", i);
        chk("basic.frame_cnt", {24'd0, fcnt_a}, 32'd1);

        for (int i = 0; i < 6; i++) apply(t2[i], "collide", i);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 3'b000, 1'b0);
            chk($sformatf("dead_tick%0d.busy", k), {31'd0, busy_a}, 32'd0);
            repeat (3) step(1'b0, 1'b1, 3'b000, 1'b0);
            chk($sformatf("dead_tick%0d.upd_req", k), {29'd0, req_a}, 32'd0);
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        chk("run_low.frame_cnt", {24'd0, fcnt_a}, 32'd0);
        step(1'b1, 1'b1, 3'b000, 1'b0);
        chk("reenable.upd_req", {29'd0, req_a}, 32'd1);
        chk("reenable.busy", {31'd0, busy_a}, 32'd1);
        repeat (5) step(1'b0, 1'b1, 3'b111, 1'b0);
        chk("reenable.died", {31'd0, died_a}, 32'd0);
        chk("reenable.busy_end", {31'd0, busy_a}, 32'd0);

        // Abort while pacman is done and ghost holds the slot.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("abort.pre_req", {29'd0, req_a}, 32'd2);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        chk("abort.upd_req", {29'd0, req_a}, 32'd0);
        chk("abort.busy", {31'd0, busy_a}, 32'd0);
        chk("abort.died", {31'd0, died_a}, 32'd0);
        chk("abort.timeout_err", {31'd0, terr_a}, 32'd0);

        // Overrun: second tick while the round is still in progress.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("ovr.before", {31'd0, ovr_a}, 32'd0);
        step(1'b1, 1'b1, 3'b000, 1'b0);
        chk("ovr.set", {31'd0, ovr_a}, 32'd1);
        repeat (5) step(1'b0, 1'b1, 3'b111, 1'b0);
        chk("ovr.busy_end", {31'd0, busy_a}, 32'd0);
        chk("ovr.sticky", {31'd0, ovr_a}, 32'd1);

        // Timeout: ghost never answers.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        cnt = (req_a == 3'b010) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 3'b000, 1'b0);
            if (req_a != 3'b010) break;
            cnt++;
        end
        chk("tmo.ghost_cycles", cnt, 32'd8);
        chk("tmo.next_req", {29'd0, req_a}, 32'd4);
        chk("tmo.timeout_err", {31'd0, terr_a}, 32'd1);
        step(1'b0, 1'b1, 3'b100, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("tmo.busy_end", {31'd0, busy_a}, 32'd0);
        chk("tmo.sticky", {31'd0, terr_a}, 32'd1);

        // Divider and frame counter wrap over 300 ticks.
        step(1'b0, 1'b0, 3'b000, 1'b0);
        r_a  = 0;
        r_b  = 0;
        pb_a = busy_a;
        pb_b = busy_b;
        for (int t = 0; t < 300; t++) begin
            step_cnt(1'b1);
            step_cnt(1'b1);
            repeat (6) step_cnt(1'b0);
        end
        chk("div1.rounds", r_a, 32'd300);
        chk("div2.rounds", r_b, 32'd150);
        chk("div1.frame_cnt", {24'd0, fcnt_a}, 32'd44);
        chk("div2.frame_cnt", {24'd0, fcnt_b}, 32'd44);

        // Asynchronous reset in the middle of a round.
        step(1'b1, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        chk("mid.pre_req", {29'd0, req_a}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst.upd_req", {29'd0, req_a}, 32'd0);
        chk("mid_rst.busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst.frame_cnt", {24'd0, fcnt_a}, 32'd0);
        chk("mid_rst.timeout_err", {31'd0, terr_a}, 32'd0);
        chk("mid_rst.overrun", {31'd0, ovr_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("post_rst.busy", {31'd0, busy_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
